// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: shares the single writeback/commit port between the
// execute units. Grant order: starved requester first, then the strict-priority
// requester, then round-robin. The winner is captured into a one-entry
// registered output stage with a valid/ready handshake.
module vx_commit_arbiter #(
  parameter int NUM_REQS    = 6,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int PRIO_REQ    = 1,
  parameter int MAX_WAIT    = 15,
  localparam int SRC_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WAIT_BITS  = $clog2(MAX_WAIT + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  output logic [NUM_REQS-1:0]                 req_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]         req_wid,
  input  logic [NUM_REQS*32-1:0]              req_pc,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     req_tmask,
  input  logic [NUM_REQS-1:0]                 req_wb,
  input  logic [NUM_REQS*5-1:0]               req_rd,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0]  req_data,
  output logic                                wb_valid,
  input  logic                                wb_ready,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [31:0]                         wb_pc,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic                                wb_wb,
  output logic [4:0]                          wb_rd,
  output logic [NUM_THREADS*32-1:0]           wb_data,
  output logic [SRC_BITS-1:0]                 wb_src
);

  // A PRIO_REQ outside the requester range turns strict priority off.
  localparam bit                   HAS_PRIO = (PRIO_REQ < NUM_REQS);
  localparam int                   PRIO_IDX = HAS_PRIO ? PRIO_REQ : 0;
  localparam int                   SUM_BITS = SRC_BITS + 1;
  localparam logic [WAIT_BITS-1:0] WAIT_SAT = WAIT_BITS'(MAX_WAIT);

  // Per-requester views of the packed input buses.
  logic [NW_BITS-1:0]          wid_arr   [NUM_REQS];
  logic [31:0]                 pc_arr    [NUM_REQS];
  logic [NUM_THREADS-1:0]      tmask_arr [NUM_REQS];
  logic [4:0]                  rd_arr    [NUM_REQS];
  logic [NUM_THREADS*32-1:0]   data_arr  [NUM_REQS];

  logic [NUM_REQS-1:0] starved;
  logic [NUM_REQS-1:0] grant_oh;
  logic                grant_any;
  logic                grant_rr;   // grant came from a pointer search (moves the pointer)
  logic [SRC_BITS-1:0] grant_idx;
  logic [SRC_BITS:0]   pick_starved;
  logic [SRC_BITS:0]   pick_valid;
  logic                load;
  logic                accept;

  logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic                      wb_valid_q;
  logic [NW_BITS-1:0]        wb_wid_q;
  logic [31:0]               wb_pc_q;
  logic [NUM_THREADS-1:0]    wb_tmask_q;
  logic                      wb_wb_q;
  logic [4:0]                wb_rd_q;
  logic [NUM_THREADS*32-1:0] wb_data_q;
  logic [SRC_BITS-1:0]       wb_src_q;

  // First set bit of mask at or after ptr, wrapping. MSB of the result flags a hit.
  // Scanning from the far end lets the closest candidate overwrite the rest.
  function automatic logic [SRC_BITS:0] rr_pick(input logic [NUM_REQS-1:0] mask,
                                                input logic [SRC_BITS-1:0] ptr);
    logic [SRC_BITS:0]   res;
    logic [SUM_BITS-1:0] sum;
    logic [SRC_BITS-1:0] idx;
    res = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SUM_BITS'(k);
      if (sum >= SUM_BITS'(NUM_REQS)) sum = sum - SUM_BITS'(NUM_REQS);
      idx = sum[SRC_BITS-1:0];
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
    logic [WAIT_BITS-1:0] wait_q, wait_d;

    assign wid_arr[gi]   = req_wid[gi*NW_BITS +: NW_BITS];
    assign pc_arr[gi]    = req_pc[gi*32 +: 32];
    assign tmask_arr[gi] = req_tmask[gi*NUM_THREADS +: NUM_THREADS];
    assign rd_arr[gi]    = req_rd[gi*5 +: 5];
    assign data_arr[gi]  = req_data[gi*NUM_THREADS*32 +: NUM_THREADS*32];

    assign starved[gi]  = req_valid[gi] && (wait_q == WAIT_SAT);
    assign grant_oh[gi] = grant_any && (grant_idx == SRC_BITS'(gi));

    // Waiting time: counts every cycle a valid requester goes unaccepted, saturating.
    always_comb begin
      wait_d = wait_q;
      if (!req_valid[gi] || req_ready[gi]) begin
        wait_d = '0;
      end else if (wait_q != WAIT_SAT) begin
        wait_d = wait_q + WAIT_BITS'(1);
      end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_d;
    end
  end

  assign pick_starved = rr_pick(starved, rr_ptr_q);
  assign pick_valid   = rr_pick(req_valid, rr_ptr_q);

  // Grant selection: starvation override, then strict priority, then round-robin.
  always_comb begin
    grant_any = 1'b0;
    grant_rr  = 1'b0;
    grant_idx = '0;
    if (pick_starved[SRC_BITS]) begin
      grant_any = 1'b1;
      grant_rr  = 1'b1;
      grant_idx = pick_starved[SRC_BITS-1:0];
    end else if (HAS_PRIO && req_valid[PRIO_IDX]) begin
      grant_any = 1'b1;
      grant_idx = SRC_BITS'(PRIO_IDX);
    end else if (pick_valid[SRC_BITS]) begin
      grant_any = 1'b1;
      grant_rr  = 1'b1;
      grant_idx = pick_valid[SRC_BITS-1:0];
    end
  end

  // The output slot can take a new entry when empty or being drained this cycle.
  assign load      = !wb_valid_q || wb_ready;
  assign accept    = load && grant_any && !reset;
  assign req_ready = (load && !reset) ? grant_oh : '0;

  // Pointer advances past the winner only for searched grants; priority grants leave it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && grant_rr) begin
      rr_ptr_d = (grant_idx == SRC_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + SRC_BITS'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Output stage: capture the winner on load, empty on load without a winner, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_wid_q   <= '0;
      wb_pc_q    <= '0;
      wb_tmask_q <= '0;
      wb_wb_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else if (load) begin
      wb_valid_q <= grant_any;
      if (grant_any) begin
        wb_wid_q   <= wid_arr[grant_idx];
        wb_pc_q    <= pc_arr[grant_idx];
        wb_tmask_q <= tmask_arr[grant_idx];
        wb_wb_q    <= req_wb[grant_idx];
        wb_rd_q    <= rd_arr[grant_idx];
        wb_data_q  <= data_arr[grant_idx];
        wb_src_q   <= grant_idx;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wid   = wb_wid_q;
  assign wb_pc    = wb_pc_q;
  assign wb_tmask = wb_tmask_q;
  assign wb_wb    = wb_wb_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Bench for vx_commit_arbiter: two instances (priority on requester 1, and
// priority disabled) share one stimulus; a behavioural model per instance
// predicts grants and the output slot, plus directed literal checks.
module tb_vx_commit_arbiter;
  localparam int N  = 6;
  localparam int T  = 4;
  localparam int NW = 2;
  localparam int MW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*NW-1:0]    req_wid;
  logic [N*32-1:0]    req_pc;
  logic [N*T-1:0]     req_tmask;
  logic [N-1:0]       req_wb;
  logic [N*5-1:0]     req_rd;
  logic [N*T*32-1:0]  req_data;
  logic               wb_ready;

  logic [N-1:0]       rdy    [2];
  logic               wbv    [2];
  logic [NW-1:0]      wid_o  [2];
  logic [31:0]        pc_o   [2];
  logic [T-1:0]       tm_o   [2];
  logic               wbwb_o [2];
  logic [4:0]         rd_o   [2];
  logic [T*32-1:0]    data_o [2];
  logic [2:0]         src_o  [2];

  vx_commit_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .PRIO_REQ(1), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_wid(req_wid), .req_pc(req_pc), .req_tmask(req_tmask), .req_wb(req_wb),
    .req_rd(req_rd), .req_data(req_data), .wb_valid(wbv[0]), .wb_ready(wb_ready),
    .wb_wid(wid_o[0]), .wb_pc(pc_o[0]), .wb_tmask(tm_o[0]), .wb_wb(wbwb_o[0]),
    .wb_rd(rd_o[0]), .wb_data(data_o[0]), .wb_src(src_o[0]));

  vx_commit_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .PRIO_REQ(N), .MAX_WAIT(MW)) u_dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_wid(req_wid), .req_pc(req_pc), .req_tmask(req_tmask), .req_wb(req_wb),
    .req_rd(req_rd), .req_data(req_data), .wb_valid(wbv[1]), .wb_ready(wb_ready),
    .wb_wid(wid_o[1]), .wb_pc(pc_o[1]), .wb_tmask(tm_o[1]), .wb_wb(wbwb_o[1]),
    .wb_rd(rd_o[1]), .wb_data(data_o[1]), .wb_src(src_o[1]));

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            prio_of [2] = '{1, N};
  int            m_wait  [2][N];
  int            m_ptr   [2];
  bit            m_v     [2];
  logic [NW-1:0] m_wid   [2];
  logic [31:0]   m_pc    [2];
  logic [T-1:0]  m_tm    [2];
  logic          m_wb    [2];
  logic [4:0]    m_rd    [2];
  logic [T*32-1:0] m_data[2];
  logic [2:0]    m_src   [2];

  // Who would be granted now for instance k; rule 1 starve, 2 priority, 3 round-robin.
  function automatic int pick(input int k, output int rule);
    rule = 0;
    for (int s = 0; s < N; s++) begin
      int i = (m_ptr[k] + s) % N;
      if (req_valid[i] && m_wait[k][i] == MW) begin rule = 1; return i; end
    end
    if (prio_of[k] < N) begin
      if (req_valid[prio_of[k]]) begin rule = 2; return prio_of[k]; end
    end
    for (int s = 0; s < N; s++) begin
      int i = (m_ptr[k] + s) % N;
      if (req_valid[i]) begin rule = 3; return i; end
    end
    return -1;
  endfunction

  int mu_rule, mu_g;
  bit mu_load, mu_acc;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ptr[k] = 0; m_v[k] = 1'b0;
        m_wid[k] = '0; m_pc[k] = '0; m_tm[k] = '0; m_wb[k] = 1'b0;
        m_rd[k] = '0; m_data[k] = '0; m_src[k] = '0;
        for (int i = 0; i < N; i++) m_wait[k][i] = 0;
      end else begin
        mu_load = !m_v[k] || wb_ready;
        mu_g    = pick(k, mu_rule);
        mu_acc  = mu_load && (mu_g >= 0);
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || (mu_acc && i == mu_g)) m_wait[k][i] = 0;
          else if (m_wait[k][i] < MW) m_wait[k][i] = m_wait[k][i] + 1;
        end
        if (mu_acc && mu_rule != 2) m_ptr[k] = (mu_g + 1) % N;
        if (mu_load) begin
          m_v[k] = mu_acc;
          if (mu_acc) begin
            m_wid[k]  = NW'(req_wid >> (mu_g * NW));
            m_pc[k]   = 32'(req_pc >> (mu_g * 32));
            m_tm[k]   = T'(req_tmask >> (mu_g * T));
            m_wb[k]   = req_wb[mu_g];
            m_rd[k]   = 5'(req_rd >> (mu_g * 5));
            m_data[k] = (T*32)'(req_data >> (mu_g * T * 32));
            m_src[k]  = 3'(mu_g);
          end
        end
      end
    end
  end

  // Compare process: every cycle, mid-period, both instances against the model.
  int           cp_rule, cp_g;
  logic [N-1:0] cp_er;
  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        cp_er = '0;
        if (!reset && (!m_v[k] || wb_ready)) begin
          cp_g = pick(k, cp_rule);
          if (cp_g >= 0) cp_er = N'(1) << cp_g;
        end
        chk($sformatf("i%0d_req_ready", k), 256'(rdy[k]), 256'(cp_er));
        chk($sformatf("i%0d_wb_valid", k), 256'(wbv[k]), 256'(m_v[k]));
        if (m_v[k]) begin
          chk($sformatf("i%0d_wb_fields", k),
              256'({wid_o[k], pc_o[k], tm_o[k], wbwb_o[k], rd_o[k], src_o[k]}),
              256'({m_wid[k], m_pc[k], m_tm[k], m_wb[k], m_rd[k], m_src[k]}));
          chk($sformatf("i%0d_wb_data", k), 256'(data_o[k]), 256'(m_data[k]));
        end
      end
      if (!reset && wbv[0] && wb_ready)
        $display("commit src=%0d wid=%0d pc=%h tmask=%b wb=%0d rd=%0d", src_o[0], wid_o[0], pc_o[0], tm_o[0], wbwb_o[0], rd_o[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [T*32-1:0] pat_data(input int i);
    logic [T*32-1:0] r;
    r = '0;
    for (int l = T - 1; l >= 0; l--) r = {r[(T-1)*32-1:0], 32'hD000_0000 | 32'(i << 8) | 32'(l)};
    return r;
  endfunction

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      req_wid[i*NW +: NW]       = NW'(i);
      req_pc[i*32 +: 32]        = 32'h1000 + 32'(i * 16);
      req_tmask[i*T +: T]       = '1;
      req_wb[i]                 = 1'b1;
      req_rd[i*5 +: 5]          = 5'(i + 1);
      req_data[i*T*32 +: T*32]  = pat_data(i);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); endtask
  task automatic do_reset(); reset = 1'b1; tick(); tick(); reset = 1'b0; endtask

  int            seq_b [6] = '{0, 2, 3, 4, 5, 0};
  logic [N-1:0]  took;

  initial begin
    // Reset with every requester asserting valid.
    reset = 1'b1; req_valid = '1; wb_ready = 1'b1;
    req_wid = '0; req_pc = '0; req_tmask = '0; req_wb = '0; req_rd = '0; req_data = '0;
    set_fields();
    tick(); checking = 1'b1;
    mid();
    chk("rst_ready0", 256'(rdy[0]), 256'(0));
    chk("rst_valid0", 256'(wbv[0]), 256'(0));
    chk("rst_pc0", 256'(pc_o[0]), 256'(0));
    chk("rst_src0", 256'(src_o[0]), 256'(0));
    tick(); reset = 1'b0;
    mid();
    chk("first_grant0", 256'(rdy[0]), 256'(6'b000010));
    chk("first_grant1", 256'(rdy[1]), 256'(6'b000001));
    tick(); mid();
    chk("first_src0", 256'(src_o[0]), 256'(1));
    chk("first_src1", 256'(src_o[1]), 256'(0));
    chk("first_pc0", 256'(pc_o[0]), 256'(32'h1010));

    // Priority requester idle: plain round-robin over the others.
    req_valid = 6'b111101; do_reset();
    for (int j = 0; j < 6; j++) begin
      mid();
      chk($sformatf("rr_grant%0d", j), 256'(rdy[0]), 256'(N'(1) << seq_b[j]));
      if (j > 0) begin
        chk($sformatf("rr_src%0d", j), 256'(src_o[0]), 256'(seq_b[j-1]));
        chk($sformatf("rr_data%0d", j), 256'(data_o[0]), 256'(pat_data(seq_b[j-1])));
      end
      tick();
    end

    // Starvation: requester 3 forced through after 15 priority grants.
    req_valid = 6'b001010; do_reset();
    for (int j = 0; j < 17; j++) begin
      mid();
      chk($sformatf("starve_grant%0d", j), 256'(rdy[0]), 256'(N'(1) << ((j == 15) ? 3 : 1)));
      tick();
    end

    // Stall: outputs frozen, no ready; on release the next entry loads at once.
    req_valid = '1; do_reset();
    mid(); chk("stall_pre", 256'(rdy[0]), 256'(6'b000010));
    tick();
    wb_ready = 1'b0; req_pc[32 +: 32] = 32'hBEEF_0000;
    for (int j = 0; j < 5; j++) begin
      mid();
      chk("stall_ready", 256'(rdy[0]), 256'(0));
      chk("stall_valid", 256'(wbv[0]), 256'(1));
      chk("stall_pc", 256'(pc_o[0]), 256'(32'h1010));
      chk("stall_src", 256'(src_o[0]), 256'(1));
      tick();
    end
    wb_ready = 1'b1;
    mid(); chk("release_ready", 256'(rdy[0]), 256'(6'b000010));
    tick(); mid();
    chk("release_pc", 256'(pc_o[0]), 256'(32'hBEEF_0000));
    chk("release_valid", 256'(wbv[0]), 256'(1));
    tick();

    // wb=0 entry passes through untouched.
    set_fields();
    req_valid = 6'b010000; req_wb[4] = 1'b0; req_rd[20 +: 5] = 5'd7; req_tmask[16 +: 4] = 4'b1010;
    do_reset();
    mid(); chk("nowb_ready", 256'(rdy[0]), 256'(6'b010000));
    tick(); mid();
    for (int k = 0; k < 2; k++)
      chk($sformatf("nowb_fields_i%0d", k), 256'({wbwb_o[k], rd_o[k], tm_o[k], src_o[k]}),
          256'({1'b0, 5'd7, 4'b1010, 3'd4}));
    set_fields();

    // Priority disabled, all valid: 0..5 repeating.
    req_valid = '1; do_reset();
    for (int j = 0; j < 12; j++) begin
      mid();
      chk($sformatf("pure_rr%0d", j), 256'(rdy[1]), 256'(N'(1) << (j % N)));
      tick();
    end

    // Randomized traffic; requesters keep fields until accepted.
    req_valid = '0; do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); took = rdy[0];
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || took[i]) begin
          req_valid[i]             = ($urandom_range(0, 99) < ((i == 1) ? 85 : 55));
          req_wid[i*NW +: NW]      = NW'($urandom);
          req_pc[i*32 +: 32]       = $urandom;
          req_tmask[i*T +: T]      = T'($urandom);
          req_wb[i]                = 1'($urandom);
          req_rd[i*5 +: 5]         = 5'($urandom);
          for (int l = 0; l < T; l++) req_data[i*T*32 + l*32 +: 32] = $urandom;
        end
      end
      wb_ready = ($urandom_range(0, 3) != 0);
    end

    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_commit_arbiter.md
Name: vx_commit_arbiter

Overview:
- Shares the single register-file writeback/commit port between the execute-stage units: ALU, LSU, CSR, MUL, FPU and GPU.
- Arbitrates the units' commit streams using a strict-priority requester plus round-robin among the rest, with starvation override.
- Drives a one-entry registered output stage with valid/ready handshake.
- Sits between the execute stage and writeback/commit.

Parameters:
- NUM_REQS, 6, number of commit requesters (index 0..NUM_REQS-1).
- NUM_THREADS, 4, lanes per warp.
- NW_BITS, 2, warp-id width.
- PRIO_REQ, 1, requester given strict priority; value NUM_REQS disables priority.
- MAX_WAIT, 15, cycles a valid non-granted requester may wait before it forces a grant; >=1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester commit valid.
- req_ready  out  NUM_REQS  per-requester accept.
- req_wid  in  NUM_REQS*NW_BITS  warp id, packed; requester i at slice i.
- req_pc  in  NUM_REQS*32  PC.
- req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- req_wb  in  NUM_REQS  writeback enable.
- req_rd  in  NUM_REQS*5  destination register.
- req_data  in  NUM_REQS*NUM_THREADS*32  result data.
- wb_valid  out  1  output entry valid.
- wb_ready  in  1  downstream accept.
- wb_wid  out  NW_BITS  forwarded warp id.
- wb_pc  out  32  forwarded PC.
- wb_tmask  out  NUM_THREADS  forwarded thread mask.
- wb_wb  out  1  forwarded writeback enable.
- wb_rd  out  5  forwarded destination register.
- wb_data  out  NUM_THREADS*32  forwarded result data.
- wb_src  out  log2(NUM_REQS)  index of the requester that produced the entry.

Behaviour:
- Reset values:
  - All wb_* outputs 0.
  - RR pointer 0.
  - All wait counters 0.
  - req_ready forced to 0 while reset is high.
  - Any entry in flight is dropped on reset; upstream retains it since no ready was given.
- Load enable: load = !wb_valid || wb_ready.
  - req_ready[g] = load && grant[g].
  - At most one req_ready bit is high per cycle.
- Grant selection (combinational, one-hot, from req_valid):
  - (1) If any requester has starved (wait==MAX_WAIT), grant the first starved index searching upward from the RR pointer with wrap.
  - (2) Otherwise, if PRIO_REQ<NUM_REQS and req_valid[PRIO_REQ], grant PRIO_REQ.
  - (3) Otherwise, grant the first valid index at/after the RR pointer, wrapping.
- RR pointer update: on an accepted grant via rule 1 or 3, pointer <= (g+1) mod NUM_REQS. A rule-2 grant leaves the pointer unchanged.
- Wait counters, one per requester, saturating:
  - Clear when the requester is accepted or req_valid is low.
  - Otherwise increment toward MAX_WAIT, including cycles where load=0.
- Output register on load with a grant: capture the granted requester's fields, set wb_src=g and wb_valid=1.
- Load with no grant: wb_valid <= 0.
- Stall (wb_valid && !wb_ready): all wb_* outputs held stable; no req_ready.
- Latency and throughput: 1 cycle from acceptance to wb_valid. Throughput is 1 entry/cycle under continuous wb_ready.
- wb=0 entries still pass through, so commit can retire them; the arbiter does not drop them.
- Upstream protocol: requesters hold fields stable while valid && !ready. The arbiter never accepts a requester whose valid is low.
- Simultaneous events: wb_ready and a new grant in the same cycle replace the entry with no bubble.

Test Plan:
- Reset held 2 cycles with all req_valid=1 -> req_ready=0, wb_valid=0. After release, first grant goes to PRIO_REQ=1 and wb_src=1 next cycle.
- req_valid=6'b111101 (priority requester idle), wb_ready=1 constant -> grants in order 0,2,3,4,5,0; one entry per cycle; wb_data matches each source.
- req_valid[1] continuously high plus req_valid[3] high, MAX_WAIT=15 -> requester 1 granted 15 times. On the 16th cycle, requester 3 is granted via starvation, its counter clears, and requester 1 resumes.
- wb_ready=0 for 5 cycles with wb_valid=1 -> wb_* outputs unchanged and req_ready=0. On release, the next entry loads the same cycle.
- Requester 4 issues wb=0, rd=7, tmask=4'b1010 -> the output shows wb_wb=0, wb_rd=7, wb_tmask=1010, wb_src=4.
- PRIO_REQ=NUM_REQS with all valid -> pure round-robin 0..5 with no starvation override firing (all waits <6).
